bcd_conv_seq: RTL and testbench
===============================

# bcd_conv_seq

Iterative binary-to-BCD converter controller. It accepts one binary word through a valid/ready handshake and sequences a shift-and-add-3 (double-dabble) datapath, processing one input bit per clock. It returns the packed BCD result through a second valid/ready handshake. It sits between producers of binary counts and display or reporting logic, replacing the combinational converter where area matters more than latency.

## Interface

Parameters:
- BIN_W, default 5: binary input width, in bits (≥ 1).
- DIGITS, default 2: number of BCD output digits (≥ 1).

Ports:
- clk  in  1: clock; all logic is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: binary word offered.
- in_ready  out  1: converter can accept a word.
- in_data  in  BIN_W: binary word, unsigned.
- out_valid  out  1: result available.
- out_ready  in  1: consumer takes the result.
- out_bcd  out  4*DIGITS: packed BCD result; digit 0 is in bits [3:0].
- busy  out  1: a conversion is in flight or a result is held.
- ovf  out  1: result does not fit in DIGITS digits. This port exists only with BCD_CONV_OVF_EN.

## Operation

- FSM states are IDLE, SHIFT and DONE.
  - IDLE: in_ready=1. On in_valid&in_ready:
    - load the binary shift register from in_data;
    - clear the BCD accumulator;
    - set the iteration counter to 0;
    - go to SHIFT.
  - SHIFT: each cycle, every BCD digit ≥ 5 gets +3. The {bcd, bin} pair then shifts left by 1, and the counter increments. After iteration BIN_W-1, go to DONE.
  - DONE: out_valid=1 and out_bcd holds the result. On out_valid&out_ready, go to IDLE.
- Arithmetic rules:
  - Digit adjustment is a 4-bit add with no carry between digits.
  - The bit shifted out of the top digit is discarded.
  - With the top bit discarded, out_bcd = in_data mod 10^DIGITS.
- in_data is sampled only on the accept edge. Changes to it at any other time are ignored.
- in_ready is 0 in SHIFT and DONE. There is no input buffering, so one word is in flight at a time.
- busy = (state != IDLE).
- out_bcd is stable for the whole time out_valid is high. In IDLE and SHIFT it holds 0.
- Reset at any point returns the block to IDLE and discards any in-flight conversion or held result.
- Reset values: in_ready=1, out_valid=0, out_bcd=0, busy=0, ovf=0.

## Timing

- The accept edge is E0. Edges E1..E_BIN_W perform the BIN_W iterations. out_valid goes high after E_BIN_W, so it is visible BIN_W cycles after the accept edge.
- With out_ready held high, out_valid is high for exactly 1 cycle. in_ready returns the cycle after that.
- Minimum accept-to-accept spacing is BIN_W+2 cycles.
- Backpressure: DONE holds indefinitely while out_ready=0. out_ready has no effect in any state other than DONE.
- A simultaneous in_valid and out_ready in DONE does not accept the input. The input is accepted one cycle later, in IDLE.
- Counter width is $clog2(BIN_W+1).

## Configuration

- BCD_CONV_OVF_EN defined:
  - The ovf port exists. It is computed on the accept edge as in_data ≥ 10^DIGITS, with the constant computed at elaboration.
  - ovf is held while out_valid=1 and cleared on return to IDLE.
  - out_bcd still carries the truncated (mod 10^DIGITS) value.
- BCD_CONV_OVF_EN undefined: there is no ovf port and no comparator. Overflow silently truncates.

## Structure

- Package bcd_pkg:
  - state typedef {IDLE, SHIFT, DONE};
  - DIGIT_W=4;
  - ADD3_THRESH=5;
  - function pow10(n), for the elaboration-time overflow constant.
- Sub-module bcd_add3_digit: one 4-bit combinational digit adjust (d ≥ 5 ? d+3 : d). It is instantiated DIGITS times in a generate loop.
- The top level holds the FSM, the counter, the shift registers and the handshake logic.

## Test plan

- Default parameters, in_data=0, out_ready=1 → out_valid 5 cycles after accept with out_bcd=8'h00, then in_ready=1.
- in_data=3, then 19, then 31, sent back-to-back with in_valid held high → out_bcd 8'h03, 8'h19, 8'h31 in order, with accepts spaced 7 cycles apart.
- Exhaustive sweep of in_data 0..31 → each out_bcd equals its decimal digits, for example 27→8'h27.
- Backpressure: in_data=12, out_ready=0 for 10 cycles → out_valid stays 1, out_bcd stays 8'h12 and in_ready stays 0. Raising out_ready then gives a single handshake and a return to IDLE.
- rst asserted on the 3rd SHIFT cycle of in_data=25 → next cycle: IDLE, out_valid=0, out_bcd=0, in_ready=1. A new in_data=7 then converts to 8'h07.
- BIN_W=8, DIGITS=2, BCD_CONV_OVF_EN defined: in_data=255 → out_bcd=8'h55, ovf=1. in_data=99 → out_bcd=8'h99, ovf=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned ADD3_THRESH = 5;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One BCD digit adjust for double-dabble: add 3 when the digit is 5 or more.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    always_comb begin
        q = d;
        if (d >= DIGIT_W'(ADD3_THRESH)) begin
            q = d + DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bcd_conv_seq.sv
// Iterative binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional overflow flag port enabled by defining BCD_CONV_OVF_EN.
module bcd_conv_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 5,
    parameter int unsigned DIGITS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BIN_W-1:0]            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DIGIT_W*DIGITS-1:0]   out_bcd,
    output logic                        busy
`ifdef BCD_CONV_OVF_EN
    ,
    output logic                        ovf
`endif
);

    localparam int unsigned BCD_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [BIN_W-1:0]    bin_sr;
    logic [BCD_W-1:0]    bcd_acc;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W+BIN_W-1:0] pair_next;
    logic [BCD_W-1:0]    bcd_next;
    logic [BIN_W-1:0]    bin_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .d (bcd_acc[g*DIGIT_W +: DIGIT_W]),
            .q (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Shifting the full {bcd, bin} pair drops the top BCD bit, giving mod 10^DIGITS.
    always_comb begin
        pair_next = {bcd_adj, bin_sr} << 1;
        bcd_next  = pair_next[BCD_W+BIN_W-1:BIN_W];
        bin_next  = pair_next[BIN_W-1:0];
    end

`ifdef BCD_CONV_OVF_EN
    localparam longint unsigned OVF_LIM = pow10(DIGITS);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bin_sr    <= '0;
            bcd_acc   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            busy      <= 1'b0;
`ifdef BCD_CONV_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr   <= in_data;
                        bcd_acc  <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
`ifdef BCD_CONV_OVF_EN
                        ovf      <= (64'(in_data) >= OVF_LIM);
`endif
                    end
                end
                SHIFT: begin
                    bcd_acc <= bcd_next;
                    bin_sr  <= bin_next;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        out_bcd   <= bcd_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_bcd   <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef BCD_CONV_OVF_EN
                        ovf       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_bcd   <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed self-checking bench for bcd_conv_seq (default 5-bit/2-digit and an 8-bit/2-digit instance).
module tb_bcd_conv_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_bcd;
    logic       busy;

    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [7:0] b_in_data = '0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b1;
    logic [7:0] b_out_bcd;
    logic       b_busy;
`ifdef BCD_CONV_OVF_EN
    logic       ovf;
    logic       b_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bcd_conv_seq #(.BIN_W(5), .DIGITS(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .busy      (busy)
`ifdef BCD_CONV_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    bcd_conv_seq #(.BIN_W(8), .DIGITS(2)) u_dut_w8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_bcd   (b_out_bcd),
        .busy      (b_busy)
`ifdef BCD_CONV_OVF_EN
        ,
        .ovf       (b_ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts v on the 5-bit instance and waits for out_valid; returns latency from accept edge.
    task automatic convert_a(input logic [4:0] v, output logic [7:0] bcd, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) check("a_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
        in_data  = ~v;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        bcd = out_bcd;
    endtask

    task automatic convert_b(input logic [7:0] v, output logic [7:0] bcd, output int lat);
        int w;
        w = 0;
        while (!b_in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!b_in_ready) check("b_ready_timeout", 32'(b_in_ready), 32'd1);
        b_in_valid = 1'b1;
        b_in_data  = v;
        tick();
        b_in_valid = 1'b0;
        b_in_data  = ~v;
        lat = 0;
        while (!b_out_valid && lat < 50) begin
            tick();
            lat++;
        end
        bcd = b_out_bcd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bcd;
        int         lat;
        logic [4:0] vals [3];
        logic [7:0] exps [3];
        int         acc_cyc [3];
        int         idx;
        int         res_idx;
        int         cyc;
        logic       acc;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bcd", 32'(out_bcd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef BCD_CONV_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif

        // Zero input, latency and return to IDLE
        convert_a(5'd0, bcd, lat);
        check("zero_lat", 32'(lat), 32'd5);
        check("zero_bcd", 32'(bcd), 32'h00);
        check("zero_busy_done", 32'(busy), 32'd1);
        check("zero_in_ready_done", 32'(in_ready), 32'd0);
        tick();
        check("zero_out_valid_after", 32'(out_valid), 32'd0);
        check("zero_in_ready_after", 32'(in_ready), 32'd1);
        check("zero_busy_after", 32'(busy), 32'd0);

        // Back-to-back with in_valid held high
        vals[0] = 5'd3;  exps[0] = 8'h03;
        vals[1] = 5'd19; exps[1] = 8'h19;
        vals[2] = 5'd31; exps[2] = 8'h31;
        idx = 0; res_idx = 0; cyc = 0;
        in_valid = 1'b1;
        in_data  = vals[0];
        while (res_idx < 3 && cyc < 100) begin
            acc = in_ready && in_valid;
            if (out_valid && out_ready) begin
                check("b2b_bcd", 32'(out_bcd), 32'(exps[res_idx]));
                res_idx++;
            end
            tick();
            cyc++;
            if (acc) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 3) in_data = vals[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_results", 32'(res_idx), 32'd3);
        check("b2b_accepts", 32'(idx), 32'd3);
        if (idx == 3) begin
            check("b2b_spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);
            check("b2b_spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd7);
        end

        // Exhaustive 0..31; expected digits written as BCD literal per value
        for (int v = 0; v < 32; v++) begin
            logic [7:0] exp_bcd;
            exp_bcd = 8'(((v / 10) << 4) | (v % 10));
            convert_a(5'(v), bcd, lat);
            check("sweep_bcd", 32'(bcd), 32'(exp_bcd));
            check("sweep_lat", 32'(lat), 32'd5);
            tick();
        end

        // Backpressure
        out_ready = 1'b0;
        convert_a(5'd12, bcd, lat);
        check("bp_first_bcd", 32'(bcd), 32'h12);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_bcd", 32'(out_bcd), 32'h12);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_bcd", 32'(out_bcd), 32'h00);

        // Reset during the third SHIFT cycle
        in_valid = 1'b1;
        in_data  = 5'd25;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_out_bcd_zero", 32'(out_bcd), 32'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_bcd", 32'(out_bcd), 32'h00);
        check("mid_rst_busy", 32'(busy), 32'd0);
        convert_a(5'd7, bcd, lat);
        check("after_rst_bcd", 32'(bcd), 32'h07);
        check("after_rst_lat", 32'(lat), 32'd5);
        tick();

        // 8-bit instance: truncation to two digits
        convert_b(8'd255, bcd, lat);
        check("w8_255_bcd", 32'(bcd), 32'h55);
        check("w8_255_lat", 32'(lat), 32'd8);
`ifdef BCD_CONV_OVF_EN
        check("w8_255_ovf", 32'(b_ovf), 32'd1);
`endif
        tick();
        check("w8_idle_valid", 32'(b_out_valid), 32'd0);
`ifdef BCD_CONV_OVF_EN
        check("w8_idle_ovf", 32'(b_ovf), 32'd0);
`endif
        convert_b(8'd99, bcd, lat);
        check("w8_99_bcd", 32'(bcd), 32'h99);
`ifdef BCD_CONV_OVF_EN
        check("w8_99_ovf", 32'(b_ovf), 32'd0);
`endif
        tick();
        convert_b(8'd100, bcd, lat);
        check("w8_100_bcd", 32'(bcd), 32'h00);
`ifdef BCD_CONV_OVF_EN
        check("w8_100_ovf", 32'(b_ovf), 32'd1);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
